// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: walks pc through instruction memory, parks one word in a
// skid register under downstream back-pressure, and handles redirects and fetch timeouts.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic        start_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    input  logic        instr_ready_i,
    output logic        fetch_err_o,
    output logic        busy_o
);
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, HOLD = 2'd2} state_e;

    localparam int unsigned       WAIT_W    = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    state_e            state_q;
    logic [31:0]       pc_q;
    logic [WAIT_W-1:0] wait_q;
    logic              instr_valid_q;
    logic [31:0]       instr_q;
    logic [31:0]       instr_pc_q;
    logic [31:0]       skid_q;
    logic [31:0]       skid_pc_q;
    logic              fetch_err_q;
    logic [31:0]       redirect_tgt;

    assign redirect_tgt  = redirect_pc_i & 32'hFFFF_FFFC;

    // The request drops in a redirect cycle so an ack arriving then is never accepted.
    assign imem_req_o    = (state_q == REQ) && !redirect_valid_i;
    assign imem_addr_o   = pc_q;
    assign instr_valid_o = instr_valid_q;
    assign instr_o       = instr_q;
    assign instr_pc_o    = instr_pc_q;
    assign fetch_err_o   = fetch_err_q;
    assign busy_o        = (state_q != IDLE);

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            wait_q        <= '0;
            instr_valid_q <= 1'b0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            skid_q        <= '0;
            skid_pc_q     <= '0;
            fetch_err_q   <= 1'b0;
        end else if (redirect_valid_i) begin
            pc_q <= redirect_tgt;
            if (state_q != IDLE) begin
                // Leaving HOLD here is what empties the skid entry.
                state_q       <= REQ;
                instr_valid_q <= 1'b0;
                wait_q        <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_q     <= REQ;
                        fetch_err_q <= 1'b0;
                        wait_q      <= '0;
                    end
                end
                REQ: begin
                    if (imem_ack_i) begin
                        wait_q <= '0;
                        pc_q   <= pc_q + 32'd4;
                        if (!instr_valid_q || instr_ready_i) begin
                            instr_q       <= imem_rdata_i;
                            instr_pc_q    <= pc_q;
                            instr_valid_q <= 1'b1;
                        end else begin
                            skid_q    <= imem_rdata_i;
                            skid_pc_q <= pc_q;
                            state_q   <= HOLD;
                        end
                    end else if (wait_q == WAIT_LAST) begin
                        fetch_err_q   <= 1'b1;
                        instr_valid_q <= 1'b0;
                        wait_q        <= '0;
                        state_q       <= IDLE;
                    end else begin
                        wait_q <= wait_q + WAIT_W'(1);
                        if (instr_valid_q && instr_ready_i) begin
                            instr_valid_q <= 1'b0;
                        end
                    end
                end
                HOLD: begin
                    if (instr_ready_i) begin
                        instr_q       <= skid_q;
                        instr_pc_q    <= skid_pc_q;
                        instr_valid_q <= 1'b1;
                        state_q       <= REQ;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the fetch address loaded at reset.
REQ-002 The block SHALL have parameter MAX_WAIT, default 15, meaning the number of cycles a memory request may stay unacknowledged before a fetch error.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 reset  in  1  asynchronous active-low reset; the block is in reset while reset=0.
REQ-005 start  in  1  one-cycle pulse that begins fetching; only sampled in IDLE.
REQ-006 redirect_valid  in  1  branch/jump redirect request.
REQ-007 redirect_pc  in  32  redirect target address.
REQ-008 imem_req  out  1  instruction-memory request.
REQ-009 imem_addr  out  32  request address, equal to the internal pc.
REQ-010 imem_ack  in  1  memory data valid; only meaningful when imem_req=1.
REQ-011 imem_rdata  in  32  fetched instruction word.
REQ-012 instr_valid  out  1  the output register holds an instruction.
REQ-013 instr  out  32  instruction word.
REQ-014 instr_pc  out  32  address of instr.
REQ-015 instr_ready  in  1  downstream consumes instr when instr_valid=1 and instr_ready=1.
REQ-016 fetch_err  out  1  sticky timeout flag.
REQ-017 busy  out  1  1 whenever the state is not IDLE.

Function
REQ-018 The FSM SHALL have states IDLE, REQ and HOLD.
REQ-019 IDLE: imem_req=0; on start=1, go to REQ and clear fetch_err.
REQ-020 REQ: imem_req=1 and imem_addr=pc.
- A transfer is imem_req=1 and imem_ack=1.
- imem_ack can arrive in the same cycle as the request.
REQ-021 On a transfer when the output register is empty or is being consumed in that cycle:
- Load instr=imem_rdata, instr_pc=pc, instr_valid=1 at the next edge.
- Set pc=pc+4.
- Stay in REQ.
REQ-022 On a transfer when instr_valid=1 and instr_ready=0:
- Capture the data and pc into a one-entry skid register.
- Set pc=pc+4 and go to HOLD.
REQ-023 HOLD: imem_req=0. When instr_ready=1, move the skid entry into the output register, keeping instr_valid=1, and return to REQ.
REQ-024 A consume with no new data SHALL clear instr_valid at the next edge.
REQ-025 pc arithmetic SHALL be modulo 2^32, so 32'hFFFF_FFFC+4 = 32'h0000_0000.
REQ-026 redirect_valid=1 in REQ or HOLD SHALL have priority over every other event:
- pc <= {redirect_pc[31:2],2'b00}.
- Clear instr_valid and the skid entry.
- Discard any imem_ack in that cycle.
- Clear the wait counter and go to REQ.
- imem_req is 0 in the redirect cycle.
REQ-027 redirect_valid=1 in IDLE SHALL load pc as in REQ-026 and remain in IDLE.
REQ-028 A wait counter SHALL count consecutive REQ cycles with imem_req=1 and imem_ack=0, and clear on a transfer or on leaving REQ.
REQ-029 When the wait counter reaches MAX_WAIT without an ack, the block SHALL at the next edge:
- Set fetch_err=1.
- Clear instr_valid and the skid entry.
- Go to IDLE.
REQ-030 start outside IDLE SHALL be ignored.
REQ-031 instr and instr_pc SHALL hold their values while instr_valid=1 and instr_ready=0.

Reset
REQ-032 While reset=0, asynchronously and regardless of state:
- state=IDLE, pc=RESET_PC.
- imem_req=0, instr_valid=0, instr=0, instr_pc=0.
- fetch_err=0, busy=0, skid empty, wait counter=0.
REQ-033 Reset asserted mid-transfer SHALL discard all in-flight data. The first edge after reset=1 SHALL only act on start or redirect_valid.

Verification
REQ-034 Reset release, start pulse, imem_ack=1 every cycle, instr_ready=1 -> instr_pc sequence 0x0, 0x4, 0x8, one per cycle; instr_valid=1 from the cycle after the first transfer.
REQ-035 instr_ready=0 for 3 cycles with ack=1 -> one instruction in the output register and one in the skid, state HOLD, imem_req=0. Raising ready -> in-order delivery, no loss or duplicate.
REQ-036 redirect_valid=1, redirect_pc=0x0000_1003, with imem_ack=1 in the same cycle -> the ack data is dropped, instr_valid=0 next cycle, next imem_addr=0x0000_1000.
REQ-037 RESET_PC=32'hFFFF_FFF8, continuous ack -> imem_addr 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
REQ-038 imem_ack held 0 after start -> fetch_err=1 after MAX_WAIT cycles, state IDLE, busy=0. A new start clears fetch_err.
REQ-039 reset pulled to 0 while in HOLD -> all outputs 0 immediately, without waiting for a clock edge.
